// File: rtl/sponge_seq_ctrl_if.sv
// Bus bundle for the sponge sequencer: message input stream, squeeze output
// stream and the start/done handshake with the permutation core.
//   master : the sequencer (drives in_ready, perm_*, out_valid/data/last)
//   slave  : the surrounding host/permutation side
interface sponge_seq_ctrl_if #(
  parameter int SWIDTH      = 320,
  parameter int RWIDTH      = 32,
  parameter int ROUND_COUNT = 10
) ();
  localparam int NBW = $clog2(RWIDTH/8) + 1;

  logic                   in_valid;
  logic                   in_ready;
  logic [RWIDTH-1:0]      in_data;
  logic                   in_last;
  logic [NBW-1:0]         in_nbytes;

  logic                   perm_start;
  logic [ROUND_COUNT-1:0] perm_rounds;
  logic [SWIDTH-1:0]      perm_state_out;
  logic [SWIDTH-1:0]      perm_state_in;
  logic                   perm_done;

  logic                   out_valid;
  logic                   out_ready;
  logic [RWIDTH-1:0]      out_data;
  logic                   out_last;

  modport master (
    input  in_valid, in_data, in_last, in_nbytes,
    output in_ready,
    output perm_start, perm_rounds, perm_state_out,
    input  perm_state_in, perm_done,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    output in_valid, in_data, in_last, in_nbytes,
    input  in_ready,
    input  perm_start, perm_rounds, perm_state_out,
    output perm_state_in, perm_done,
    input  out_valid, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/sponge_seq_ctrl.sv
// Sponge sequencer. Holds the only copy of the sponge state, runs the
// init permutation, absorbs padded message words, then squeezes out_words
// rate-width words, calling the shared permutation core between steps.
//   clk, reset        : clock, async active-high reset
//   start             : begin a hash (only honoured in IDLE)
//   init_state        : initial sponge state, captured on start
//   rounds_a/rounds_b : init/final and intermediate round counts
//   out_words         : number of squeeze words
//   busy, done        : hash in progress / one-cycle completion pulse
//   bus (master)      : message stream, output stream, permutation handshake
module sponge_seq_ctrl #(
  parameter int SWIDTH      = 320,
  parameter int RWIDTH      = 32,
  parameter int ROUND_COUNT = 10,
  parameter int OWIDTH      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [SWIDTH-1:0]      init_state,
  input  logic [ROUND_COUNT-1:0] rounds_a,
  input  logic [ROUND_COUNT-1:0] rounds_b,
  input  logic [OWIDTH-1:0]      out_words,
  output logic                   busy,
  output logic                   done,
  sponge_seq_ctrl_if.master      bus
);
  localparam int RB  = RWIDTH / 8;
  localparam int NBW = $clog2(RB) + 1;
  localparam logic [RWIDTH-1:0] PAD_MSB = {8'h80, {(RWIDTH-8){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, PERM_ISSUE, PERM_WAIT, ABSORB, PAD_WORD, SQUEEZE, FINISH
  } state_t;

  state_t                 fsm_q, fsm_d, ret_q, ret_d;
  logic [SWIDTH-1:0]      state_q, state_d;
  logic [ROUND_COUNT-1:0] ra_q, ra_d, rb_q, rb_d, prnd_q, prnd_d;
  logic [OWIDTH-1:0]      nw_q, nw_d, cnt_q, cnt_d;
  logic [RWIDTH-1:0]      pad_w;
  logic                   full_w, last_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q   <= IDLE;
      ret_q   <= IDLE;
      state_q <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      prnd_q  <= '0;
      nw_q    <= '0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      ret_q   <= ret_d;
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      prnd_q  <= prnd_d;
      nw_q    <= nw_d;
      cnt_q   <= cnt_d;
    end
  end

  // Short last word: keep bytes below in_nbytes, put 0x80 in byte in_nbytes.
  // Byte 0 sits at the MSBs.
  always_comb begin
    pad_w = '0;
    for (int i = 0; i < RB; i++) begin
      if (i < int'(bus.in_nbytes))
        pad_w[RWIDTH-1-8*i -: 8] = bus.in_data[RWIDTH-1-8*i -: 8];
      else if (i == int'(bus.in_nbytes))
        pad_w[RWIDTH-1-8*i -: 8] = 8'h80;
    end
  end

  assign full_w = (bus.in_nbytes == NBW'(RB));
  // Only meaningful in SQUEEZE with nw_q != 0, so nw_q-1 never underflows there.
  assign last_w = (cnt_q == nw_q - OWIDTH'(1));

  always_comb begin
    fsm_d          = fsm_q;
    ret_d          = ret_q;
    state_d        = state_q;
    ra_d           = ra_q;
    rb_d           = rb_q;
    prnd_d         = prnd_q;
    nw_d           = nw_q;
    cnt_d          = cnt_q;
    bus.in_ready   = 1'b0;
    bus.out_valid  = 1'b0;
    bus.perm_start = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          state_d = init_state;
          ra_d    = rounds_a;
          rb_d    = rounds_b;
          nw_d    = out_words;
          cnt_d   = '0;
          prnd_d  = rounds_a;
          ret_d   = ABSORB;
          fsm_d   = PERM_ISSUE;
        end
      end
      PERM_ISSUE: begin
        bus.perm_start = 1'b1;
        fsm_d          = PERM_WAIT;
      end
      PERM_WAIT: begin
        if (bus.perm_done) begin
          state_d = bus.perm_state_in;
          fsm_d   = ret_q;
        end
      end
      ABSORB: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          fsm_d = PERM_ISSUE;
          if (!bus.in_last) begin
            state_d[SWIDTH-1 -: RWIDTH] = state_q[SWIDTH-1 -: RWIDTH] ^ bus.in_data;
            prnd_d = rb_q;
            ret_d  = ABSORB;
          end else if (!full_w) begin
            state_d[SWIDTH-1 -: RWIDTH] = state_q[SWIDTH-1 -: RWIDTH] ^ pad_w;
            prnd_d = ra_q;
            ret_d  = SQUEEZE;
          end else begin
            // Full last word: padding needs a whole extra block.
            state_d[SWIDTH-1 -: RWIDTH] = state_q[SWIDTH-1 -: RWIDTH] ^ bus.in_data;
            prnd_d = rb_q;
            ret_d  = PAD_WORD;
          end
        end
      end
      PAD_WORD: begin
        state_d[SWIDTH-1 -: RWIDTH] = state_q[SWIDTH-1 -: RWIDTH] ^ PAD_MSB;
        prnd_d = ra_q;
        ret_d  = SQUEEZE;
        fsm_d  = PERM_ISSUE;
      end
      SQUEEZE: begin
        if (nw_q == '0) begin
          fsm_d = FINISH;
        end else begin
          bus.out_valid = 1'b1;
          if (bus.out_ready) begin
            cnt_d = cnt_q + OWIDTH'(1);
            if (last_w) begin
              fsm_d = FINISH;
            end else begin
              prnd_d = rb_q;
              ret_d  = SQUEEZE;
              fsm_d  = PERM_ISSUE;
            end
          end
        end
      end
      FINISH:  fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  assign bus.perm_rounds    = prnd_q;
  assign bus.perm_state_out = state_q;
  assign bus.out_data       = state_q[SWIDTH-1 -: RWIDTH];
  assign bus.out_last       = bus.out_valid && last_w;
  assign busy               = (fsm_q != IDLE) && (fsm_q != FINISH);
  assign done               = (fsm_q == FINISH);
endmodule
